switch_merge: RTL and testbench
===============================

Name: switch_merge

Overview:
- 2-to-1 merge block: the reverse direction of the address-routing switch.
- Accepts two independent streams (port A, port B), each carrying vld/addr/data beats. Buffers each stream in its own small FIFO.
- Drains both FIFOs onto a single vld/addr/data output bus using round-robin arbitration.
- Sits downstream of the switch's addr_a/data_a and addr_b/data_b outputs, recombining traffic into one stream.

Parameters:
- ADDR_WIDTH, 8, width of addr on all ports
- DATA_WIDTH, 16, width of data on all ports
- DEPTH, 4, entries per input FIFO; power of two, minimum 2

Ports:
- clk  input  1  system clock, all state on rising edge
- rstn  input  1  asynchronous active-low reset
- vld_a  input  1  port A beat valid
- addr_a  input  ADDR_WIDTH  port A address
- data_a  input  DATA_WIDTH  port A data
- rdy_a  output  1  port A FIFO can accept a beat this cycle
- vld_b  input  1  port B beat valid
- addr_b  input  ADDR_WIDTH  port B address
- data_b  input  DATA_WIDTH  port B data
- rdy_b  output  1  port B FIFO can accept a beat this cycle
- vld  output  1  merged output beat valid (registered)
- addr  output  ADDR_WIDTH  merged output address (registered)
- data  output  DATA_WIDTH  merged output data (registered)
- src  output  1  source of current output beat: 0 = A, 1 = B
- drop_cnt  output  8  saturating count of beats dropped at either port

Behaviour:
- Reset (rstn low, asynchronous):
  - Both FIFOs emptied (pointers and counts to 0).
  - vld=0, addr=0, data=0, src=0, drop_cnt=0.
  - Arbiter last-grant = B, so A wins the first contention.
  - Reset asserted mid-operation discards all buffered beats. No output beat appears until new input arrives after reset release.
- Readiness: rdy_x = (count_x != DEPTH). It depends only on the registered count; it is not affected by a same-cycle pop.
- Push: on a rising edge with vld_x=1 and rdy_x=1, {addr_x, data_x} is written to FIFO x.
- Drop: vld_x=1 with rdy_x=0 discards the beat and increments drop_cnt by 1.
  - Simultaneous drops on A and B add 2.
  - drop_cnt saturates at 255 and never wraps.
- Arbitration, evaluated each rising edge on the pre-edge FIFO counts:
  - Neither FIFO non-empty: output register loads vld=0; addr, data and src hold their previous values.
  - Exactly one FIFO non-empty: pop its head.
  - Both non-empty: pop the port opposite to last-grant.
  - A pop loads vld=1, addr/data = head entry, src = granted port. Last-grant updates to the granted port.
- Output has no backpressure: one beat is emitted per cycle at most, and each vld=1 cycle is a distinct beat.
- Latency:
  - A beat pushed into an empty FIFO at edge N is popped at edge N+1 if granted. It is visible on vld/addr/data during the cycle after edge N+1.
  - It is not popped in the same cycle it is written; there is no bypass.
- Simultaneous push and pop on the same FIFO: both take effect and the count is unchanged. A full FIFO still shows rdy=0 in that cycle.
- Ordering: per-port order is preserved. Across ports, order is set by the arbiter only.
- Throughput: sustained vld_a=vld_b=1 exceeds output bandwidth. The FIFOs fill, rdy deasserts, and beats are dropped and counted. Under steady contention the output alternates A, B, A, B.
- FIFO pointers are log2(DEPTH) bits and wrap naturally. The count is log2(DEPTH)+1 bits.

Test Plan:
- Reset then single A beat: vld_a=1, addr_a=0x12, data_a=0xBEEF for one cycle -> two edges later vld=1, addr=0x12, data=0xBEEF, src=0 for exactly one cycle; drop_cnt=0.
- Contention: A (0x01/0x1111) and B (0x02/0x2222) pushed in the same cycle after reset -> output A beat then B beat on consecutive cycles.
- Round-robin fairness: 3 beats queued in each FIFO -> output src sequence 0,1,0,1,0,1 with no vld gaps.
- Overflow: hold vld_a=1 for 10 cycles with vld_b=0, DEPTH=4 -> no drops, because A drains one per cycle. Then hold vld_a=vld_b=1 continuously -> rdy_a/rdy_b toggle low, drop_cnt increments, and all output addr values appear in per-port push order.
- Saturation: force over 300 dropped beats -> drop_cnt reads 255 and stays there.
- Reset mid-stream: assert rstn=0 with both FIFOs holding beats -> vld=0 and rdy_a=rdy_b=1 immediately (asynchronously); no stale beat is emitted after release.

Source files
------------

// File: rtl/switch_merge_if.sv
// Bus bundle for the 2-to-1 merge block: two input streams (A, B) with
// per-port ready, plus the merged registered output and drop counter.
interface switch_merge_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
);
    logic                  vld_a;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [DATA_WIDTH-1:0] data_a;
    logic                  rdy_a;
    logic                  vld_b;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [DATA_WIDTH-1:0] data_b;
    logic                  rdy_b;
    logic                  vld;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  src;
    logic [7:0]            drop_cnt;

    // Traffic source / consumer side
    modport master (
        output vld_a, addr_a, data_a, vld_b, addr_b, data_b,
        input  rdy_a, rdy_b, vld, addr, data, src, drop_cnt
    );

    // Merge block side
    modport slave (
        input  vld_a, addr_a, data_a, vld_b, addr_b, data_b,
        output rdy_a, rdy_b, vld, addr, data, src, drop_cnt
    );
endinterface

// File: rtl/switch_merge.sv
// 2-to-1 stream merge: each input port is buffered in its own FIFO, and the
// two FIFOs are drained round-robin onto one registered output bus. Beats
// arriving at a full FIFO are dropped and counted (saturating at 255).
module switch_merge #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic          clk,
    input  logic          rstn,
    switch_merge_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Per-port views so both FIFOs come from one generate body (0 = A, 1 = B)
    logic [1:0]    in_vld;
    logic [EW-1:0] in_beat [2];
    logic [EW-1:0] head    [2];
    logic [1:0]    rdy;
    logic [1:0]    push;
    logic [1:0]    drop;
    logic [1:0]    nonempty;
    logic [1:0]    pop;

    assign in_vld     = {bus.vld_b, bus.vld_a};
    assign in_beat[0] = {bus.addr_a, bus.data_a};
    assign in_beat[1] = {bus.addr_b, bus.data_b};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [EW-1:0] mem [DEPTH];
            logic [PW-1:0] wr_ptr_q, wr_ptr_d;
            logic [PW-1:0] rd_ptr_q, rd_ptr_d;
            logic [CW-1:0] count_q, count_d;

            // Ready looks only at the registered count, never at a same-cycle pop
            assign rdy[gi]      = (count_q != FULL);
            assign push[gi]     = in_vld[gi] & rdy[gi];
            assign drop[gi]     = in_vld[gi] & ~rdy[gi];
            assign nonempty[gi] = (count_q != '0);
            assign head[gi]     = mem[rd_ptr_q];

            // Storage write; contents need no reset since pointers define validity
            always_ff @(posedge clk) begin
                if (push[gi]) begin
                    mem[wr_ptr_q] <= in_beat[gi];
                end
            end

            // Pointer and occupancy next-state; push and pop may coincide
            always_comb begin
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                count_d  = count_q;
                if (push[gi]) begin
                    wr_ptr_d = wr_ptr_q + PW'(1);
                end
                if (pop[gi]) begin
                    rd_ptr_d = rd_ptr_q + PW'(1);
                end
                count_d = count_q + CW'(push[gi]) - CW'(pop[gi]);
            end

            // Pointer and occupancy registers
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    count_q  <= '0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                    count_q  <= count_d;
                end
            end
        end
    endgenerate

    logic                  vld_q, vld_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  src_q, src_d;
    logic                  last_q, last_d;   // last granted port, 1 = B
    logic [7:0]            drop_q, drop_d;
    logic                  grant_vld;
    logic                  grant_b;
    logic [8:0]            drop_sum;

    // Round-robin grant on pre-edge occupancy; load the output register on a pop
    always_comb begin
        grant_vld = |nonempty;
        grant_b   = (&nonempty) ? ~last_q : nonempty[1];
        pop       = 2'b00;
        vld_d     = grant_vld;
        addr_d    = addr_q;
        data_d    = data_q;
        src_d     = src_q;
        last_d    = last_q;
        if (grant_vld) begin
            pop[grant_b]     = 1'b1;
            {addr_d, data_d} = head[grant_b];
            src_d            = grant_b;
            last_d           = grant_b;
        end
    end

    // Drop counter adds up to two per cycle and clamps at 255
    always_comb begin
        drop_sum = 9'(drop_q) + 9'(drop[0]) + 9'(drop[1]);
        drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    // Output, arbiter and drop-counter registers; last grant resets to B so A wins first
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            src_q  <= 1'b0;
            last_q <= 1'b1;
            drop_q <= '0;
        end else begin
            vld_q  <= vld_d;
            addr_q <= addr_d;
            data_q <= data_d;
            src_q  <= src_d;
            last_q <= last_d;
            drop_q <= drop_d;
        end
    end

    assign bus.rdy_a    = rdy[0];
    assign bus.rdy_b    = rdy[1];
    assign bus.vld      = vld_q;
    assign bus.addr     = addr_q;
    assign bus.data     = data_q;
    assign bus.src      = src_q;
    assign bus.drop_cnt = drop_q;
endmodule

// File: tb/tb_switch_merge.sv
// Directed bench for switch_merge: literal checks at the points listed in the
// test plan, plus a small queue model that tracks every cycle.
module tb_switch_merge;
    localparam int AW    = 8;
    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic clk;
    logic rstn;
    int   total = 0;
    int   bad   = 0;

    switch_merge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    switch_merge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [AW+DW-1:0] qa [$];
    logic [AW+DW-1:0] qb [$];
    bit               m_last;
    bit               m_vld;
    logic [AW-1:0]    m_addr;
    logic [DW-1:0]    m_data;
    bit               m_src;
    int               m_drop;

    logic [AW-1:0] rr_addr [6] = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22};
    bit            rr_src  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        qa.delete();
        qb.delete();
        m_last = 1'b1;
        m_vld  = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_src  = 1'b0;
        m_drop = 0;
    endtask

    // One clock: drive inputs, advance model, then check all outputs
    task automatic tick(input bit va, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                        input bit vb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
        bit pa, pb, dra, drb, nea, neb, gb;
        logic [AW+DW-1:0] beat;
        check("rdy_a", 32'(bus.rdy_a), 32'(qa.size() != DEPTH));
        check("rdy_b", 32'(bus.rdy_b), 32'(qb.size() != DEPTH));
        bus.vld_a = va; bus.addr_a = aa; bus.data_a = da;
        bus.vld_b = vb; bus.addr_b = ab; bus.data_b = db;
        pa  = va && (qa.size() != DEPTH);
        pb  = vb && (qb.size() != DEPTH);
        dra = va && !pa;
        drb = vb && !pb;
        nea = (qa.size() != 0);
        neb = (qb.size() != 0);
        if (nea || neb) begin
            gb = (nea && neb) ? !m_last : neb;
            beat = gb ? qb.pop_front() : qa.pop_front();
            {m_addr, m_data} = beat;
            m_src  = gb;
            m_last = gb;
            m_vld  = 1'b1;
        end else begin
            m_vld = 1'b0;
        end
        if (pa) qa.push_back({aa, da});
        if (pb) qb.push_back({ab, db});
        m_drop = m_drop + int'(dra) + int'(drb);
        if (m_drop > 255) m_drop = 255;
        @(posedge clk);
        #1;
        $display("cycle t=%0t vld=%0b src=%0b addr=%02h data=%04h drop=%0d",
                 $time, bus.vld, bus.src, bus.addr, bus.data, bus.drop_cnt);
        check("m_vld", 32'(bus.vld), 32'(m_vld));
        check("m_addr", 32'(bus.addr), 32'(m_addr));
        check("m_data", 32'(bus.data), 32'(m_data));
        check("m_src", 32'(bus.src), 32'(m_src));
        check("m_drop", 32'(bus.drop_cnt), 32'(m_drop));
    endtask

    task automatic idle();
        tick(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        bus.vld_a = 1'b0; bus.addr_a = '0; bus.data_a = '0;
        bus.vld_b = 1'b0; bus.addr_b = '0; bus.data_b = '0;
        model_reset();
        #1;
        check("rst_vld", 32'(bus.vld), 32'h0);
        check("rst_rdy_a", 32'(bus.rdy_a), 32'h1);
        check("rst_rdy_b", 32'(bus.rdy_b), 32'h1);
        check("rst_drop", 32'(bus.drop_cnt), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        check("rst_addr", 32'(bus.addr), 32'h0);
        check("rst_data", 32'(bus.data), 32'h0);
        check("rst_src", 32'(bus.src), 32'h0);

        // Single A beat: visible two edges after it is presented
        tick(1'b1, 8'h12, 16'hBEEF, 1'b0, '0, '0);
        check("single_not_yet", 32'(bus.vld), 32'h0);
        idle();
        check("single_vld", 32'(bus.vld), 32'h1);
        check("single_addr", 32'(bus.addr), 32'h12);
        check("single_data", 32'(bus.data), 32'hBEEF);
        check("single_src", 32'(bus.src), 32'h0);
        check("single_drop", 32'(bus.drop_cnt), 32'h0);
        idle();
        check("single_one_cycle", 32'(bus.vld), 32'h0);

        // Contention right after reset: A first, then B
        do_reset();
        tick(1'b1, 8'h01, 16'h1111, 1'b1, 8'h02, 16'h2222);
        idle();
        check("cont_a_vld", 32'(bus.vld), 32'h1);
        check("cont_a_src", 32'(bus.src), 32'h0);
        check("cont_a_addr", 32'(bus.addr), 32'h01);
        check("cont_a_data", 32'(bus.data), 32'h1111);
        idle();
        check("cont_b_vld", 32'(bus.vld), 32'h1);
        check("cont_b_src", 32'(bus.src), 32'h1);
        check("cont_b_addr", 32'(bus.addr), 32'h02);
        check("cont_b_data", 32'(bus.data), 32'h2222);
        idle();
        check("cont_idle", 32'(bus.vld), 32'h0);

        // Round-robin: three beats per port, output alternates with no gaps
        for (int k = 0; k < 8; k++) begin
            if (k < 3)
                tick(1'b1, 8'(8'h10 + k), 16'(16'hA000 + k), 1'b1, 8'(8'h20 + k), 16'(16'hB000 + k));
            else
                idle();
            if (k >= 1 && k <= 6) begin
                check("rr_vld", 32'(bus.vld), 32'h1);
                check("rr_src", 32'(bus.src), 32'(rr_src[k-1]));
                check("rr_addr", 32'(bus.addr), 32'(rr_addr[k-1]));
            end
        end
        check("rr_end_vld", 32'(bus.vld), 32'h0);

        // A alone for 10 cycles drains one per cycle: never fills, never drops
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 8'(8'h30 + i), 16'(16'hC000 + i), 1'b0, '0, '0);
            check("a_only_rdy", 32'(bus.rdy_a), 32'h1);
        end
        repeat (4) idle();
        check("a_only_drop", 32'(bus.drop_cnt), 32'h0);

        // Sustained both ports: one drop per cycle from the 7th edge on
        for (int i = 0; i < 30; i++)
            tick(1'b1, 8'(8'h40 + i), 16'(16'hD000 + i), 1'b1, 8'(8'h80 + i), 16'(16'hE000 + i));
        check("sustain_drop", 32'(bus.drop_cnt), 32'd24);

        // Keep pushing past 300 total drops: counter pins at 255
        for (int i = 0; i < 300; i++)
            tick(1'b1, 8'(i), 16'(16'h5000 + i), 1'b1, 8'(8'hFF - i), 16'(16'h6000 + i));
        check("sat_drop", 32'(bus.drop_cnt), 32'd255);
        repeat (5) tick(1'b1, 8'h77, 16'h7777, 1'b1, 8'h88, 16'h8888);
        check("sat_hold", 32'(bus.drop_cnt), 32'd255);

        // Reset with both FIFOs holding beats: nothing stale afterwards
        do_reset();
        for (int i = 0; i < 5; i++) begin
            idle();
            check("post_rst_vld", 32'(bus.vld), 32'h0);
        end
        tick(1'b0, '0, '0, 1'b1, 8'h5A, 16'h1234);
        idle();
        check("post_rst_b_src", 32'(bus.src), 32'h1);
        check("post_rst_b_addr", 32'(bus.addr), 32'h5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
